// File: rtl/tlb_maint_unit.sv
// TLB maintenance unit: owns the shadow copy of every TLB entry, executes
// TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB for the commit stage, and mirrors each
// shadow update to the mmu lookup array as a registered one-hot write strobe.

`ifndef _TLB_ENTRY_NUM
`define _TLB_ENTRY_NUM 16
`endif

package tlb_maint_pkg;
   localparam int TLB_NUM_DEFAULT = `_TLB_ENTRY_NUM;

   typedef struct packed {
      logic [18:0] vppn;
      logic        huge_page;
      logic        g;
      logic [9:0]  asid;
      logic        e;
   } tlb_key_t;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_data_t;

   typedef struct packed {
      tlb_key_t  key;
      tlb_data_t data0;
      tlb_data_t data1;
   } tlb_entry_t;

   typedef struct packed {
      logic [TLB_NUM_DEFAULT-1:0] tlb_write_req;
      tlb_entry_t                 tlb_write_entry;
   } tlb_write_req_t;
endpackage

module tlb_maint_unit #(
   parameter int TLB_ENTRY_NUM = `_TLB_ENTRY_NUM,
   localparam int IDX_W = $clog2(TLB_ENTRY_NUM)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [2:0]                   req_op,
   input  logic [4:0]                   inv_op,
   input  logic [9:0]                   inv_asid,
   input  logic [31:0]                  inv_va,
   input  logic [IDX_W-1:0]             csr_index,
   input  logic [18:0]                  csr_vppn,
   input  logic [9:0]                   csr_asid,
   input  tlb_maint_pkg::tlb_entry_t    csr_entry,
   output logic                         resp_valid,
   output logic                         resp_err,
   output logic                         srch_hit,
   output logic [IDX_W-1:0]             srch_index,
   output tlb_maint_pkg::tlb_entry_t    rd_entry,
   output tlb_maint_pkg::tlb_write_req_t tlb_write_req_o
);
   import tlb_maint_pkg::tlb_entry_t;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   typedef enum logic [1:0] {IDLE, EXEC, SCAN, DONE} state_t;

   state_t                   state, state_nx;
   tlb_entry_t               shadow [TLB_ENTRY_NUM];
   logic [IDX_W-1:0]         fill_ptr;
   logic [IDX_W-1:0]         scan_cnt;
   logic [4:0]               inv_op_q;
   logic [9:0]               inv_asid_q;
   logic [18:0]              inv_vppn_q;

   logic                     accept;
   logic                     inv_legal;
   logic [4:0]               cur_op;
   logic [9:0]               cur_asid;
   logic [18:0]              cur_vppn;
   logic [IDX_W-1:0]         cur_idx;
   tlb_entry_t               cur_ent;
   logic                     inv_hit;
   logic                     scan_active;
   logic                     wr_en;
   logic [IDX_W-1:0]         wr_idx;
   tlb_entry_t               wr_entry;
   logic [TLB_ENTRY_NUM-1:0] wr_onehot;
   logic                     srch_hit_c;
   logic [IDX_W-1:0]         srch_idx_c;
   logic                     unused_va;

   // Huge pages only compare the upper ten vppn bits.
   function automatic logic vppn_match(input tlb_entry_t ent, input logic [18:0] vppn);
      if (ent.key.huge_page) return ent.key.vppn[18:9] == vppn[18:9];
      return ent.key.vppn == vppn;
   endfunction

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign inv_legal = (inv_op <= 5'd6);
   assign unused_va = ^inv_va[12:0];

   // Evaluates the INVTLB predicate for the entry being scanned; entry 0 is scanned on the accept edge using live operands.
   always_comb begin
      cur_op   = inv_op_q;
      cur_asid = inv_asid_q;
      cur_vppn = inv_vppn_q;
      cur_idx  = scan_cnt;
      if (state == IDLE) begin
         cur_op   = inv_op;
         cur_asid = inv_asid;
         cur_vppn = inv_va[31:13];
         cur_idx  = '0;
      end
      cur_ent = shadow[cur_idx];
      inv_hit = 1'b0;
      case (cur_op)
         5'd0, 5'd1: inv_hit = 1'b1;
         5'd2:       inv_hit = cur_ent.key.g;
         5'd3:       inv_hit = !cur_ent.key.g;
         5'd4:       inv_hit = !cur_ent.key.g && (cur_ent.key.asid == cur_asid);
         5'd5:       inv_hit = !cur_ent.key.g && (cur_ent.key.asid == cur_asid) && vppn_match(cur_ent, cur_vppn);
         5'd6:       inv_hit = (cur_ent.key.g || (cur_ent.key.asid == cur_asid)) && vppn_match(cur_ent, cur_vppn);
         default:    inv_hit = 1'b0;
      endcase
      scan_active = (accept && (req_op == OP_INV) && inv_legal) || (state == SCAN);
   end

   // Selects the single shadow write for this edge: WR, FILL, or an INVTLB clear of a valid matching entry.
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = '0;
      wr_entry = '0;
      if (accept && (req_op == OP_WR)) begin
         wr_en    = 1'b1;
         wr_idx   = csr_index;
         wr_entry = csr_entry;
      end else if (accept && (req_op == OP_FILL)) begin
         wr_en    = 1'b1;
         wr_idx   = fill_ptr;
         wr_entry = csr_entry;
      end else if (scan_active && inv_hit && cur_ent.key.e) begin
         wr_en           = 1'b1;
         wr_idx          = cur_idx;
         wr_entry        = cur_ent;
         wr_entry.key.e  = 1'b0;
      end
      wr_onehot = '0;
      if (wr_en) wr_onehot = TLB_ENTRY_NUM'(1) << wr_idx;
   end

   // Associative search over the shadow; scanning downwards lets the lowest matching index win.
   always_comb begin
      srch_hit_c = 1'b0;
      srch_idx_c = '0;
      for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
         if (shadow[i].key.e && (shadow[i].key.g || (shadow[i].key.asid == csr_asid)) &&
             vppn_match(shadow[i], csr_vppn)) begin
            srch_hit_c = 1'b1;
            srch_idx_c = IDX_W'(i);
         end
      end
   end

   // Next-state: INVTLB with a legal op walks every entry, everything else completes in one cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req_valid) state_nx = ((req_op == OP_INV) && inv_legal) ? SCAN : EXEC;
         EXEC: state_nx = IDLE;
         SCAN: if (scan_cnt == IDX_W'(TLB_ENTRY_NUM - 1)) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Free-running fill pointer used as the TLBFILL victim index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fill_ptr <= '0;
      else     fill_ptr <= fill_ptr + 1'b1;
   end

   // Shadow update, registered mmu strobe, response pulse and operand capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TLB_ENTRY_NUM; i++) shadow[i] <= '0;
         scan_cnt        <= '0;
         inv_op_q        <= '0;
         inv_asid_q      <= '0;
         inv_vppn_q      <= '0;
         resp_valid      <= 1'b0;
         resp_err        <= 1'b0;
         srch_hit        <= 1'b0;
         srch_index      <= '0;
         rd_entry        <= '0;
         tlb_write_req_o <= '0;
      end else begin
         resp_valid      <= 1'b0;
         resp_err        <= 1'b0;
         srch_hit        <= 1'b0;
         srch_index      <= '0;
         rd_entry        <= '0;
         tlb_write_req_o <= '0;
         if (wr_en) begin
            shadow[wr_idx]                  <= wr_entry;
            tlb_write_req_o.tlb_write_req   <= wr_onehot;
            tlb_write_req_o.tlb_write_entry <= wr_entry;
         end
         if (state == SCAN) scan_cnt <= scan_cnt + 1'b1;
         if (state == DONE) resp_valid <= 1'b1;
         if (accept) begin
            case (req_op)
               OP_SRCH: begin
                  resp_valid <= 1'b1;
                  srch_hit   <= srch_hit_c;
                  srch_index <= srch_idx_c;
               end
               OP_RD: begin
                  resp_valid <= 1'b1;
                  if (shadow[csr_index].key.e) rd_entry <= shadow[csr_index];
               end
               OP_WR, OP_FILL: resp_valid <= 1'b1;
               OP_INV: begin
                  if (inv_legal) begin
                     inv_op_q   <= inv_op;
                     inv_asid_q <= inv_asid;
                     inv_vppn_q <= inv_va[31:13];
                     scan_cnt   <= IDX_W'(1);
                  end else begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end
               end
               default: begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_tlb_maint_unit.sv
// Self-checking bench for tlb_maint_unit: a table of single-cycle operations
// followed by hand-written INVTLB, FILL, huge-page and reset-abort sequences.
module tb_tlb_maint_unit;
   import tlb_maint_pkg::*;

   localparam int N     = 16;
   localparam int IDX_W = 4;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [4:0]       inv_op;
   logic [9:0]       inv_asid;
   logic [31:0]      inv_va;
   logic [IDX_W-1:0] csr_index;
   logic [18:0]      csr_vppn;
   logic [9:0]       csr_asid;
   tlb_entry_t       csr_entry;
   logic             resp_valid;
   logic             resp_err;
   logic             srch_hit;
   logic [IDX_W-1:0] srch_index;
   tlb_entry_t       rd_entry;
   tlb_write_req_t   tlb_write_req_o;

   int total = 0;
   int bad   = 0;
   int model_fp;

   tlb_maint_unit #(.TLB_ENTRY_NUM(N)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
      .csr_index(csr_index), .csr_vppn(csr_vppn), .csr_asid(csr_asid),
      .csr_entry(csr_entry), .resp_valid(resp_valid), .resp_err(resp_err),
      .srch_hit(srch_hit), .srch_index(srch_index), .rd_entry(rd_entry),
      .tlb_write_req_o(tlb_write_req_o)
   );

   always #5 clk = ~clk;

   // Reference fill pointer: counts clock edges since reset.
   always @(posedge clk or posedge rst) begin
      if (rst) model_fp <= 0;
      else     model_fp <= (model_fp + 1) % N;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  iop;
      logic [3:0]  idx;
      logic [18:0] vppn;
      logic [9:0]  asid;
      tlb_entry_t  ent;
      logic        exp_err;
      logic        exp_hit;
      logic [3:0]  exp_sidx;
      logic [15:0] exp_strobe;
      tlb_entry_t  exp_rd;
   } vec_t;

   function automatic tlb_entry_t mk_entry(input logic [18:0] vppn, input logic [9:0] asid,
                                           input logic g, input logic huge, input logic e,
                                           input logic [19:0] ppn);
      tlb_entry_t t;
      t = '0;
      t.key.vppn      = vppn;
      t.key.asid      = asid;
      t.key.g         = g;
      t.key.huge_page = huge;
      t.key.e         = e;
      t.data0.ppn     = ppn;
      t.data0.v       = 1'b1;
      t.data1.ppn     = ppn + 20'd1;
      t.data1.d       = 1'b1;
      return t;
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for req_ready at a negedge, drives one request, returns at the negedge of cycle T+1.
   task automatic apply_stimulus(input logic [2:0] op, input logic [4:0] iop, input logic [3:0] idx,
                                 input logic [18:0] vppn, input logic [9:0] asid, input tlb_entry_t ent,
                                 input logic [9:0] iasid, input logic [31:0] iva);
      int waited = 0;
      while (!req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_output("req_ready_wait", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      inv_op    = iop;
      csr_index = idx;
      csr_vppn  = vppn;
      csr_asid  = asid;
      csr_entry = ent;
      inv_asid  = iasid;
      inv_va    = iva;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 3'd7;
      csr_entry = '0;
      csr_vppn  = '0;
      inv_va    = '0;
   endtask

   task automatic do_wr(input logic [3:0] idx, input tlb_entry_t ent);
      apply_stimulus(OP_WR, 5'd0, idx, 19'd0, 10'd0, ent, 10'd0, 32'd0);
   endtask

   task automatic do_srch(input logic [18:0] vppn, input logic [9:0] asid);
      apply_stimulus(OP_SRCH, 5'd0, 4'd0, vppn, asid, '0, 10'd0, 32'd0);
   endtask

   task automatic do_inv(input logic [4:0] iop, input logic [9:0] iasid, input logic [31:0] iva);
      apply_stimulus(OP_INV, iop, 4'd0, 19'd0, 10'd0, '0, iasid, iva);
   endtask

   vec_t       vecs [12];
   tlb_entry_t ea, eb, ebz, ec, ent3 [N], eh, en, xe;
   logic [15:0] exp_s;
   logic        saw_bad;

   initial begin
      ea  = mk_entry(19'h12345, 10'd5, 1'b0, 1'b0, 1'b1, 20'hABCDE);
      eb  = mk_entry(19'h12345, 10'd9, 1'b1, 1'b0, 1'b1, 20'h11111);
      ebz = mk_entry(19'h12345, 10'd9, 1'b1, 1'b0, 1'b0, 20'h11111);
      //            op       iop   idx   vppn        asid   ent  err   hit   sidx  strobe    rd
      vecs[0]  = '{OP_WR,   5'd0, 4'd3, 19'h0,      10'd0, ea,  1'b0, 1'b0, 4'd0, 16'h0008, '0};
      vecs[1]  = '{OP_SRCH, 5'd0, 4'd0, 19'h12345,  10'd5, '0,  1'b0, 1'b1, 4'd3, 16'h0000, '0};
      vecs[2]  = '{OP_RD,   5'd0, 4'd3, 19'h0,      10'd0, '0,  1'b0, 1'b0, 4'd0, 16'h0000, ea};
      vecs[3]  = '{OP_RD,   5'd0, 4'd4, 19'h0,      10'd0, '0,  1'b0, 1'b0, 4'd0, 16'h0000, '0};
      vecs[4]  = '{OP_SRCH, 5'd0, 4'd0, 19'h12345,  10'd6, '0,  1'b0, 1'b0, 4'd0, 16'h0000, '0};
      vecs[5]  = '{OP_WR,   5'd0, 4'd1, 19'h0,      10'd0, eb,  1'b0, 1'b0, 4'd0, 16'h0002, '0};
      vecs[6]  = '{OP_SRCH, 5'd0, 4'd0, 19'h12345,  10'd5, '0,  1'b0, 1'b1, 4'd1, 16'h0000, '0};
      vecs[7]  = '{3'd5,    5'd0, 4'd0, 19'h0,      10'd0, '0,  1'b1, 1'b0, 4'd0, 16'h0000, '0};
      vecs[8]  = '{OP_INV,  5'd7, 4'd0, 19'h0,      10'd0, '0,  1'b1, 1'b0, 4'd0, 16'h0000, '0};
      vecs[9]  = '{OP_WR,   5'd0, 4'd1, 19'h0,      10'd0, ebz, 1'b0, 1'b0, 4'd0, 16'h0002, '0};
      vecs[10] = '{OP_SRCH, 5'd0, 4'd0, 19'h12345,  10'd5, '0,  1'b0, 1'b1, 4'd3, 16'h0000, '0};
      vecs[11] = '{OP_RD,   5'd0, 4'd1, 19'h0,      10'd0, '0,  1'b0, 1'b0, 4'd0, 16'h0000, '0};

      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; inv_op = '0; inv_asid = '0; inv_va = '0;
      csr_index = '0; csr_vppn = '0; csr_asid = '0; csr_entry = '0;
      repeat (3) @(negedge clk);
      check_output("reset_req_ready",  req_ready, 1'b1);
      check_output("reset_resp_valid", resp_valid, 1'b0);
      check_output("reset_resp_err",   resp_err, 1'b0);
      check_output("reset_srch",       {srch_hit, srch_index}, '0);
      check_output("reset_rd_entry",   rd_entry, '0);
      check_output("reset_strobe",     tlb_write_req_o, '0);
      rst = 1'b0;
      @(negedge clk);

      // Table of single-cycle operations, each checked in T+1 and again in T+2.
      for (int v = 0; v < 12; v++) begin
         apply_stimulus(vecs[v].op, vecs[v].iop, vecs[v].idx, vecs[v].vppn, vecs[v].asid,
                        vecs[v].ent, 10'd0, 32'd0);
         check_output($sformatf("v%0d_resp_valid", v), resp_valid, 1'b1);
         check_output($sformatf("v%0d_resp_err", v), resp_err, vecs[v].exp_err);
         check_output($sformatf("v%0d_srch_hit", v), srch_hit, vecs[v].exp_hit);
         check_output($sformatf("v%0d_srch_index", v), srch_index, vecs[v].exp_sidx);
         check_output($sformatf("v%0d_rd_entry", v), rd_entry, vecs[v].exp_rd);
         check_output($sformatf("v%0d_strobe", v), tlb_write_req_o.tlb_write_req, vecs[v].exp_strobe);
         if (vecs[v].exp_strobe != 16'h0)
            check_output($sformatf("v%0d_wr_entry", v), tlb_write_req_o.tlb_write_entry, vecs[v].ent);
         @(negedge clk);
         check_output($sformatf("v%0d_pulse_end", v), {resp_valid, tlb_write_req_o.tlb_write_req}, '0);
      end

      // INVTLB op 3 clears only non-global entries 0, 2, 7; global entry 9 survives.
      do_reset();
      for (int i = 0; i < N; i++) ent3[i] = '0;
      ent3[0] = mk_entry(19'h00100, 10'd1, 1'b0, 1'b0, 1'b1, 20'h00010);
      ent3[2] = mk_entry(19'h00102, 10'd1, 1'b0, 1'b0, 1'b1, 20'h00012);
      ent3[7] = mk_entry(19'h00107, 10'd1, 1'b0, 1'b0, 1'b1, 20'h00017);
      ent3[9] = mk_entry(19'h00099, 10'd4, 1'b1, 1'b0, 1'b1, 20'h00019);
      do_wr(4'd0, ent3[0]);
      do_wr(4'd2, ent3[2]);
      do_wr(4'd7, ent3[7]);
      do_wr(4'd9, ent3[9]);
      do_inv(5'd3, 10'd0, 32'd0);
      for (int k = 1; k <= N; k++) begin
         exp_s = 16'h0;
         if (k - 1 == 0 || k - 1 == 2 || k - 1 == 7) exp_s = 16'h1 << (k - 1);
         check_output($sformatf("inv3_strobe_T%0d", k), tlb_write_req_o.tlb_write_req, exp_s);
         if (exp_s != 16'h0) begin
            xe = ent3[k - 1];
            xe.key.e = 1'b0;
            check_output($sformatf("inv3_entry_T%0d", k), tlb_write_req_o.tlb_write_entry, xe);
         end
         check_output($sformatf("inv3_resp_T%0d", k), {resp_valid, req_ready}, 2'b00);
         @(negedge clk);
      end
      check_output("inv3_resp_valid", {resp_valid, resp_err}, 2'b10);
      do_srch(19'h00099, 10'd7);
      check_output("inv3_srch_global", {srch_hit, srch_index}, {1'b1, 4'd9});
      do_srch(19'h00102, 10'd1);
      check_output("inv3_srch_cleared", {srch_hit, srch_index}, {1'b0, 4'd0});

      // Held FILL requests starting at fill_ptr=6 land every other cycle and wrap 14 -> 0.
      ec = mk_entry(19'h7777A, 10'd2, 1'b0, 1'b0, 1'b1, 20'h0CAFE);
      @(negedge clk);
      for (int w = 0; w < 40 && model_fp != 6; w++) @(negedge clk);
      check_output("fill_align", model_fp, 6);
      req_valid = 1'b1;
      req_op    = OP_FILL;
      csr_entry = ec;
      for (int j = 0; j < 6; j++) begin
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("fill%0d_strobe", j), tlb_write_req_o.tlb_write_req,
                      16'h1 << ((6 + 2 * j) % N));
         check_output($sformatf("fill%0d_entry", j), tlb_write_req_o.tlb_write_entry, ec);
         check_output($sformatf("fill%0d_resp", j), resp_valid, 1'b1);
         if (j == 5) req_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("fill%0d_gap", j), tlb_write_req_o.tlb_write_req, 16'h0);
      end
      req_op = 3'd7;
      do_srch(19'h7777A, 10'd2);
      check_output("fill_srch_wrap", {srch_hit, srch_index}, {1'b1, 4'd0});

      // Huge page: vppn[18:9]=0x0AB matches any low bits; a 4 KiB neighbour must not.
      eh = mk_entry({10'h0AB, 9'h000}, 10'd3, 1'b0, 1'b1, 1'b1, 20'h0BEEF);
      en = mk_entry(19'h157FE, 10'd3, 1'b0, 1'b0, 1'b1, 20'h0D00D);
      do_wr(4'd6, eh);
      do_wr(4'd2, en);
      do_srch({10'h0AB, 9'h1FF}, 10'd3);
      check_output("huge_srch_hit", {srch_hit, srch_index}, {1'b1, 4'd6});
      do_inv(5'd5, 10'd3, 32'h2AC0_0000);
      for (int k = 1; k <= N; k++) begin
         exp_s = (k - 1 == 6) ? 16'h0040 : 16'h0000;
         check_output($sformatf("inv5_strobe_T%0d", k), tlb_write_req_o.tlb_write_req, exp_s);
         @(negedge clk);
      end
      check_output("inv5_resp_valid", {resp_valid, resp_err}, 2'b10);
      do_srch({10'h0AB, 9'h1FF}, 10'd3);
      check_output("inv5_srch_miss", srch_hit, 1'b0);
      do_srch(19'h157FE, 10'd3);
      check_output("inv5_neighbour_kept", {srch_hit, srch_index}, {1'b1, 4'd2});

      // Reset in the middle of an INVTLB scan aborts it with no response.
      do_inv(5'd0, 10'd0, 32'd0);
      check_output("abort_T1_strobe", tlb_write_req_o.tlb_write_req, 16'h0001);
      @(negedge clk);
      check_output("abort_T2_strobe", tlb_write_req_o.tlb_write_req, 16'h0000);
      @(negedge clk);
      check_output("abort_T3_strobe", tlb_write_req_o.tlb_write_req, 16'h0004);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("abort_rst_outputs", {resp_valid, resp_err, srch_hit, tlb_write_req_o.tlb_write_req}, '0);
      check_output("abort_rst_ready", req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      saw_bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (resp_valid || (tlb_write_req_o.tlb_write_req != 16'h0)) saw_bad = 1'b1;
      end
      check_output("abort_no_late_activity", saw_bad, 1'b0);
      do_srch(19'h00099, 10'd0);
      check_output("abort_srch_miss", {srch_hit, srch_index}, {1'b0, 4'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
